i_decode: RTL

I_DECODE -- requirements
Module: i_decode

---
 rtl/i_decode.sv | 116 +++++++++++
 1 files changed

// File: rtl/i_decode.sv
// ID stage: register file, control decode, load-use detection and the ID/EX pipeline register.
// Latency: ID_EX_* is one cycle after IF_ID_instr. stall is combinational and holds PC/IF/ID while a bubble is inserted.
module i_decode #(
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instr,
  input  logic [31:0] IF_ID_npc,
  input  logic        EX_MEM_PCSrc,
  input  logic        MEM_WB_regwrite,
  input  logic [4:0]  MEM_WB_writereg,
  input  logic [31:0] MEM_WB_writedata,
  output logic        stall,
  output logic [1:0]  ID_EX_wb,
  output logic [2:0]  ID_EX_m,
  output logic [3:0]  ID_EX_ex,
  output logic [31:0] ID_EX_npc,
  output logic [31:0] ID_EX_readdat1,
  output logic [31:0] ID_EX_readdat2,
  output logic [31:0] ID_EX_sign_ext,
  output logic [4:0]  ID_EX_instr_2016,
  output logic [4:0]  ID_EX_instr_1511
);

  logic [31:0] rf_q [32];

  logic [1:0]  wb_q, wb_d;
  logic [2:0]  m_q, m_d;
  logic [3:0]  ex_q, ex_d;
  logic [31:0] npc_q, rd1_q, rd1_d, rd2_q, rd2_d, sext_q, sext_d;
  logic [4:0]  rt_fld_q, rd_fld_q;

  logic [5:0]  opcode;
  logic [4:0]  rs, rt;
  logic        hazard;
  logic        wb_en;

  assign opcode = IF_ID_instr[31:26];
  assign rs     = IF_ID_instr[25:21];
  assign rt     = IF_ID_instr[20:16];
  assign wb_en  = MEM_WB_regwrite && (MEM_WB_writereg != 5'd0);
  assign sext_d = {{16{IF_ID_instr[15]}}, IF_ID_instr[15:0]};

  // r0 is forced to zero on read so a bypassed write to r0 can never leak through.
  always_comb begin
    rd1_d = rf_q[rs];
    rd2_d = rf_q[rt];
    if (WB_BYPASS && wb_en) begin
      if (MEM_WB_writereg == rs) rd1_d = MEM_WB_writedata;
      if (MEM_WB_writereg == rt) rd2_d = MEM_WB_writedata;
    end
    if (rs == 5'd0) rd1_d = '0;
    if (rt == 5'd0) rd2_d = '0;
  end

  assign hazard = m_q[1] && (rt_fld_q != 5'd0) &&
                  ((rt_fld_q == rs) || (rt_fld_q == rt));
  assign stall  = hazard && !EX_MEM_PCSrc;

  always_comb begin
    wb_d = '0;
    m_d  = '0;
    ex_d = '0;
    unique case (opcode)
      6'h00: begin wb_d = 2'b10; m_d = 3'b000; ex_d = 4'b1100; end
      6'h23: begin wb_d = 2'b11; m_d = 3'b010; ex_d = 4'b0001; end
      6'h2B: begin wb_d = 2'b00; m_d = 3'b001; ex_d = 4'b0001; end
      6'h04: begin wb_d = 2'b00; m_d = 3'b100; ex_d = 4'b0010; end
      default: ;
    endcase
    // Bubble on load-use stall or taken-branch flush; data fields still load.
    if (stall || EX_MEM_PCSrc) begin
      wb_d = '0;
      m_d  = '0;
      ex_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
      wb_q     <= '0;
      m_q      <= '0;
      ex_q     <= '0;
      npc_q    <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      sext_q   <= '0;
      rt_fld_q <= '0;
      rd_fld_q <= '0;
    end else begin
      if (wb_en) rf_q[MEM_WB_writereg] <= MEM_WB_writedata;
      wb_q     <= wb_d;
      m_q      <= m_d;
      ex_q     <= ex_d;
      npc_q    <= IF_ID_npc;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      sext_q   <= sext_d;
      rt_fld_q <= IF_ID_instr[20:16];
      rd_fld_q <= IF_ID_instr[15:11];
    end
  end

  assign ID_EX_wb         = wb_q;
  assign ID_EX_m          = m_q;
  assign ID_EX_ex         = ex_q;
  assign ID_EX_npc        = npc_q;
  assign ID_EX_readdat1   = rd1_q;
  assign ID_EX_readdat2   = rd2_q;
  assign ID_EX_sign_ext   = sext_q;
  assign ID_EX_instr_2016 = rt_fld_q;
  assign ID_EX_instr_1511 = rd_fld_q;

endmodule
